// File: rtl/kitchen_timer_pkg.sv
// kitchen_timer_pkg
// Shared types and helpers for the kitchen timer input path.
//   state_t       : keypad FSM states (SCAN, DEBOUNCE, PRESSED, RELEASE)
//   KEY_CLEAR     : key code that clears the digit register
//   ROWS_IDLE     : row pattern with no key pulling any row low
//   keymap()      : (row index, column index) -> 4-bit hex key code
//   single_low()  : true when exactly one (active-low) row bit is low
//   low_index()   : index of the lowest low row bit
package kitchen_timer_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] ROWS_IDLE = 4'hF;

  // PmodKYPD layout:
  //   r0: 1 2 3 A
  //   r1: 4 5 6 B
  //   r2: 7 8 9 C
  //   r3: 0 F E D
  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Several low rows on one column means ghosting or a multi-key chord;
  // only a single low row is a usable key.
  function automatic logic single_low(input logic [3:0] rows);
    logic hit;
    case (rows)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) begin
        idx = 2'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// keypad_scan
// Column strobe generator and row synchronizer for a 4x4 matrix keypad.
//   clk      in   system clock
//   reset    in   asynchronous, active-low reset
//   row      in   [3:0] keypad rows, active-low, asynchronous to clk
//   freeze   in   hold the current column at the end of a slot
//   col      out  [3:0] column strobes, active-low, one-cold
//   col_idx  out  [1:0] index of the driven column
//   row_sync out  [3:0] synchronized rows
//   sample   out  high on the last count of each slot; row_sync is valid
//                 for the driven column and has settled SCAN_DIV-1 cycles
module keypad_scan #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic       freeze,
  output logic [3:0] col,
  output logic [1:0] col_idx,
  output logic [3:0] row_sync,
  output logic       sample
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] slot_cnt_reg;
  logic [1:0]       col_idx_reg;
  logic [3:0]       row_meta_reg;
  logic [3:0]       row_sync_reg;
  logic             slot_end;

  assign slot_end = (slot_cnt_reg == SLOT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_cnt_reg <= '0;
      col_idx_reg  <= 2'd0;
      row_meta_reg <= 4'hF;
      row_sync_reg <= 4'hF;
    end else begin
      row_meta_reg <= row;
      row_sync_reg <= row_meta_reg;
      if (slot_end) begin
        slot_cnt_reg <= '0;
        // freeze is evaluated in the same cycle the FSM decides, so a hit
        // seen on this sample keeps the column where the key was found.
        if (!freeze) begin
          col_idx_reg <= col_idx_reg + 2'd1;
        end
      end else begin
        slot_cnt_reg <= slot_cnt_reg + CNT_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign col[gi] = (col_idx_reg != 2'(gi));
    end
  endgenerate

  assign col_idx  = col_idx_reg;
  assign row_sync = row_sync_reg;
  assign sample   = slot_end;

endmodule

// File: rtl/keypad_entry.sv
// keypad_entry
// Scans a 4x4 keypad, debounces presses and releases, emits one key_valid
// pulse per accepted key and shifts digit keys into a 4-digit BCD register.
//   clk       in   system clock
//   reset     in   asynchronous, active-low reset
//   row       in   [3:0] keypad rows, active-low, asynchronous to clk
//   col       out  [3:0] column strobes, active-low, one-cold
//   key_valid out  one-cycle pulse per accepted key
//   key_code  out  [3:0] hex code of the last accepted key (held)
//   digits    out  [15:0] four BCD digits, [15:12] leftmost
module keypad_entry
  import kitchen_timer_pkg::*;
#(
  parameter int SCAN_DIV         = 100000,
  parameter int DEBOUNCE_SAMPLES = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] digits
);

  localparam int DB_W = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [DB_W-1:0] DB_TARGET = DB_W'(DEBOUNCE_SAMPLES);

  logic [1:0] scan_col_idx;
  logic [3:0] row_sync;
  logic       sample;
  logic       scan_freeze;

  state_t         state_reg, state_next;
  logic [1:0]     key_col_reg, key_col_next;
  logic [1:0]     key_row_reg, key_row_next;
  logic [DB_W-1:0] match_cnt_reg, match_cnt_next;
  logic [DB_W-1:0] rel_cnt_reg, rel_cnt_next;
  logic           key_valid_reg, key_valid_next;
  logic [3:0]     key_code_reg, key_code_next;
  logic [15:0]    digits_reg, digits_next;

  logic           accept;
  logic [3:0]     key_row_mask;
  logic [3:0]     new_code;

  keypad_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .freeze   (scan_freeze),
    .col      (col),
    .col_idx  (scan_col_idx),
    .row_sync (row_sync),
    .sample   (sample)
  );

  // Frozen whenever the FSM is (or is about to be) tracking a key. Using the
  // next state lets a fresh hit stop the column on the same sample edge and
  // lets an abort/release resume at c+1 on that edge.
  assign scan_freeze = (state_next != SCAN);

  // Row pattern that matches the latched key: only its row low.
  assign key_row_mask = ~(4'b0001 << key_row_reg);
  assign new_code     = keymap(key_row_reg, key_col_reg);

  always_comb begin
    state_next     = state_reg;
    key_col_next   = key_col_reg;
    key_row_next   = key_row_reg;
    match_cnt_next = match_cnt_reg;
    rel_cnt_next   = rel_cnt_reg;
    key_valid_next = 1'b0;
    key_code_next  = key_code_reg;
    digits_next    = digits_reg;
    accept         = 1'b0;

    case (state_reg)
      SCAN: begin
        if (sample && single_low(row_sync)) begin
          key_col_next   = scan_col_idx;
          key_row_next   = low_index(row_sync);
          match_cnt_next = DB_W'(1);
          state_next     = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (sample) begin
          if (row_sync == key_row_mask) begin
            if (match_cnt_reg + DB_W'(1) == DB_TARGET) begin
              match_cnt_next = '0;
              state_next     = PRESSED;
              accept         = 1'b1;
            end else begin
              match_cnt_next = match_cnt_reg + DB_W'(1);
            end
          end else begin
            match_cnt_next = '0;
            state_next     = SCAN;
          end
        end
      end

      PRESSED: begin
        if (sample && (row_sync == ROWS_IDLE)) begin
          rel_cnt_next = DB_W'(1);
          state_next   = RELEASE;
        end
      end

      RELEASE: begin
        if (sample) begin
          if (row_sync == ROWS_IDLE) begin
            if (rel_cnt_reg + DB_W'(1) == DB_TARGET) begin
              rel_cnt_next = '0;
              state_next   = SCAN;
            end else begin
              rel_cnt_next = rel_cnt_reg + DB_W'(1);
            end
          end else begin
            // Release bounce: back to held without a second pulse.
            rel_cnt_next = '0;
            state_next   = PRESSED;
          end
        end
      end

      default: begin
        state_next = SCAN;
      end
    endcase

    // key_code and digits are registered alongside key_valid so all three
    // change together in the pulse cycle.
    if (accept) begin
      key_valid_next = 1'b1;
      key_code_next  = new_code;
      if (new_code <= 4'd9) begin
        digits_next = {digits_reg[11:0], new_code};
      end else if (new_code == KEY_CLEAR) begin
        digits_next = 16'h0000;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= SCAN;
      key_col_reg   <= 2'd0;
      key_row_reg   <= 2'd0;
      match_cnt_reg <= '0;
      rel_cnt_reg   <= '0;
      key_valid_reg <= 1'b0;
      key_code_reg  <= 4'h0;
      digits_reg    <= 16'h0000;
    end else begin
      state_reg     <= state_next;
      key_col_reg   <= key_col_next;
      key_row_reg   <= key_row_next;
      match_cnt_reg <= match_cnt_next;
      rel_cnt_reg   <= rel_cnt_next;
      key_valid_reg <= key_valid_next;
      key_code_reg  <= key_code_next;
      digits_reg    <= digits_next;
    end
  end

  assign key_valid = key_valid_reg;
  assign key_code  = key_code_reg;
  assign digits    = digits_reg;

endmodule

// File: tb/tb_keypad_entry.sv
`timescale 1ns/1ps
module tb_keypad_entry;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] digits;

  // One bit per key, index r*4+c; the keypad model pulls row r low while
  // any pressed key of that row sits on a driven (low) column.
  logic [15:0] press_mask = 16'h0000;
  logic [63:0] keys_tbl   = 64'h123A_456B_789C_0FED;

  int checks = 0;
  int failures = 0;
  int pulse_count = 0;
  logic [19:0] sb_q[$];         // {key_code, digits} expected per pulse
  logic [15:0] model_digits = 16'h0000;
  logic        prev_valid = 1'b0;

  keypad_entry #(
    .SCAN_DIV         (4),
    .DEBOUNCE_SAMPLES (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .digits    (digits)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (press_mask[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] tb_key(input int r, input int c);
    int idx;
    idx = r * 4 + c;
    return keys_tbl[63 - 4*idx -: 4];
  endfunction

  task automatic push_expect(input logic [3:0] code);
    if (code <= 4'd9) model_digits = {model_digits[11:0], code};
    else if (code == 4'hC) model_digits = 16'h0000;
    sb_q.push_back({code, model_digits});
  endtask

  // Scoreboard side: every pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (key_valid) begin
      pulse_count++;
      check("kv_not_consecutive", {31'd0, prev_valid}, 32'd0);
      check("pulse_expected", {31'd0, (sb_q.size() > 0)}, 32'd1);
      if (sb_q.size() > 0) begin
        logic [19:0] e;
        e = sb_q.pop_front();
        $display("pulse: key_code=%h digits=%h (expected %h / %h)", key_code, digits, e[19:16], e[15:0]);
        check("key_code", {28'd0, key_code}, {28'd0, e[19:16]});
        check("digits", {16'd0, digits}, {16'd0, e[15:0]});
      end
    end
    prev_valid = key_valid;
  end

  task automatic press(input int r, input int c, input int hold, input bit expect_pulse);
    int base;
    base = pulse_count;
    if (expect_pulse) push_expect(tb_key(r, c));
    press_mask[r*4+c] = 1'b1;
    repeat (hold) @(negedge clk);
    press_mask = 16'h0000;
    repeat (40) @(negedge clk);
    check($sformatf("pulses_key_%0h", tb_key(r, c)), pulse_count - base, expect_pulse ? 1 : 0);
    check("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit found;
    logic [3:0] last_col;
    logic [3:0] exp_col;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_col", col, 4'b1110);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_code", key_code, 4'h0);
    check("rst_digits", digits, 16'h0000);

    // Column cycling after release: after posedge k, column = (k/4)%4
    reset = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k % 4 == 2) begin
        exp_col = ~(4'b0001 << ((k / 4) % 4));
        check($sformatf("scan_col_k%0d", k), col, exp_col);
      end
    end

    // Single press '1'
    press(0, 0, 80, 1'b1);
    check("digits_single", digits, 16'h0001);

    // Digit shifting 1..5
    press(0, 0, 80, 1'b1);
    press(0, 1, 80, 1'b1);
    press(0, 2, 80, 1'b1);
    press(1, 0, 80, 1'b1);
    press(1, 1, 80, 1'b1);
    check("digits_shift", digits, 16'h2345);

    // Reach 1234, then clear, then a non-digit
    press(0, 0, 80, 1'b1);
    press(0, 1, 80, 1'b1);
    press(0, 2, 80, 1'b1);
    press(1, 0, 80, 1'b1);
    check("digits_1234", digits, 16'h1234);
    press(2, 3, 80, 1'b1);
    check("clear_code", key_code, 4'hC);
    check("clear_digits", digits, 16'h0000);
    press(0, 3, 80, 1'b1);
    check("a_code", key_code, 4'hA);
    check("a_digits", digits, 16'h0000);

    // Bounce: '7' held for two samples starting at the top of column 0's slot
    found = 1'b0;
    last_col = col;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (col == 4'b1110 && last_col != 4'b1110) begin
        found = 1'b1;
        break;
      end
      last_col = col;
    end
    check("col0_found", {31'd0, found}, 32'd1);
    press(2, 0, 8, 1'b0);

    // Release glitch of one sample during PRESSED on '5'
    base = pulse_count;
    push_expect(tb_key(1, 1));
    press_mask[5] = 1'b1;
    repeat (40) @(negedge clk);
    press_mask = 16'h0000;
    repeat (4) @(negedge clk);
    press_mask[5] = 1'b1;
    repeat (40) @(negedge clk);
    press_mask = 16'h0000;
    repeat (40) @(negedge clk);
    check("glitch_pulses", pulse_count - base, 1);
    check("glitch_digits", digits, 16'h0005);

    // Two rows low on one column: '1' and '4' together
    base = pulse_count;
    press_mask = 16'h0011;
    repeat (80) @(negedge clk);
    press_mask = 16'h0000;
    repeat (40) @(negedge clk);
    check("multikey_pulses", pulse_count - base, 0);

    // Reset during PRESSED of '9'
    base = pulse_count;
    push_expect(tb_key(2, 2));
    press_mask[10] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (pulse_count != base) begin
        found = 1'b1;
        break;
      end
    end
    check("nine_pulse_seen", {31'd0, found}, 32'd1);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_col", col, 4'b1110);
    check("midrst_key_valid", key_valid, 1'b0);
    check("midrst_key_code", key_code, 4'h0);
    check("midrst_digits", digits, 16'h0000);
    model_digits = 16'h0000;
    repeat (10) @(negedge clk);

    // Release reset with '9' still held: fresh press
    base = pulse_count;
    push_expect(tb_key(2, 2));
    reset = 1'b1;
    repeat (80) @(negedge clk);
    press_mask = 16'h0000;
    repeat (40) @(negedge clk);
    check("rerelease_pulses", pulse_count - base, 1);
    check("rerelease_digits", digits, 16'h0009);
    check("final_sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
